// File: rtl/sync_dlatch_bank.sv
// Multi-channel synchronous replacement for a level-sensitive D latch, with change flags and capture counters.
// Latency: D to Q is one clk cycle (level mode) or one cycle after the En rising edge (edge mode).
// Backpressure: none; every channel accepts En/D/Clr every cycle.
module sync_dlatch_bank #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] D,
  input  logic [CHANNELS-1:0]       En,
  input  logic [CHANNELS-1:0]       Mode,
  input  logic [CHANNELS-1:0]       Clr,
  output logic [CHANNELS*WIDTH-1:0] Q,
  output logic [CHANNELS-1:0]       Updated,
  output logic [CHANNELS*CNT_W-1:0] Cap_Cnt
);

  // Registered state and next-state
  logic [CHANNELS-1:0]       en_d_q;
  logic [CHANNELS*WIDTH-1:0] q_q, q_d;
  logic [CHANNELS-1:0]       upd_q, upd_d;
  logic [CHANNELS*CNT_W-1:0] cnt_q, cnt_d;

  // Per-channel rising edge of En and the resulting write strobe.
  // Level mode writes whenever En is high; edge mode only on the rise.
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] wr;

  assign rise = En & ~en_d_q;
  assign wr   = En & (~Mode | rise);

  // Next-state for held value, sticky change flag and saturating capture counter
  always_comb begin
    q_d   = q_q;
    upd_d = upd_q;
    cnt_d = cnt_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (wr[i]) begin
        q_d[i*WIDTH +: WIDTH] = D[i*WIDTH +: WIDTH];
      end
      // A real change beats a same-cycle clear so no update is ever lost
      if (wr[i] && (D[i*WIDTH +: WIDTH] != q_q[i*WIDTH +: WIDTH])) begin
        upd_d[i] = 1'b1;
      end else if (Clr[i]) begin
        upd_d[i] = 1'b0;
      end
      // Clear restarts the count, still counting a coincident rise
      if (Clr[i]) begin
        cnt_d[i*CNT_W +: CNT_W] = rise[i] ? CNT_W'(1) : '0;
      end else if (rise[i] && (cnt_q[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
        cnt_d[i*CNT_W +: CNT_W] = cnt_q[i*CNT_W +: CNT_W] + CNT_W'(1);
      end
    end
  end

  // State registers; reset clears everything immediately, independent of clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_d_q <= '0;
      q_q    <= '0;
      upd_q  <= '0;
      cnt_q  <= '0;
    end else begin
      en_d_q <= En;
      q_q    <= q_d;
      upd_q  <= upd_d;
      cnt_q  <= cnt_d;
    end
  end

  assign Q       = q_q;
  assign Updated = upd_q;
  assign Cap_Cnt = cnt_q;

endmodule

// File: tb/tb_sync_dlatch_bank.sv
// Directed testbench for sync_dlatch_bank with hand-computed expectations
// plus a behavioural per-channel model for the concurrent-activity section.
// Inputs change and outputs are sampled 1 time unit after the rising clk edge.
module tb_sync_dlatch_bank;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 4;
  localparam int CNT_W    = 8;

  logic                      clk;
  logic                      rst_n;
  logic [CHANNELS*WIDTH-1:0] D;
  logic [CHANNELS-1:0]       En;
  logic [CHANNELS-1:0]       Mode;
  logic [CHANNELS-1:0]       Clr;
  logic [CHANNELS*WIDTH-1:0] Q;
  logic [CHANNELS-1:0]       Updated;
  logic [CHANNELS*CNT_W-1:0] Cap_Cnt;

  int n_vec;
  int n_err;

  // Behavioural reference state
  logic [WIDTH-1:0] m_q   [CHANNELS];
  logic             m_upd [CHANNELS];
  logic [CNT_W-1:0] m_cnt [CHANNELS];
  logic             m_en  [CHANNELS];

  sync_dlatch_bank #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .D       (D),
    .En      (En),
    .Mode    (Mode),
    .Clr     (Clr),
    .Q       (Q),
    .Updated (Updated),
    .Cap_Cnt (Cap_Cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance the reference model by one clk edge using the current inputs
  task automatic model_step();
    logic r;
    logic w;
    logic [WIDTH-1:0] dv;
    for (int i = 0; i < CHANNELS; i++) begin
      dv = D[i*WIDTH +: WIDTH];
      r  = En[i] & ~m_en[i];
      w  = En[i] & (~Mode[i] | r);
      if (w && dv != m_q[i]) m_upd[i] = 1'b1;
      else if (Clr[i])       m_upd[i] = 1'b0;
      if (Clr[i])                  m_cnt[i] = r ? 8'd1 : 8'd0;
      else if (r && m_cnt[i] != 8'hFF) m_cnt[i] = m_cnt[i] + 8'd1;
      if (w) m_q[i] = dv;
      m_en[i] = En[i];
    end
  endtask

  task automatic model_check(input int cyc);
    logic [CHANNELS*WIDTH-1:0] eq;
    logic [CHANNELS-1:0]       eu;
    logic [CHANNELS*CNT_W-1:0] ec;
    for (int i = 0; i < CHANNELS; i++) begin
      eq[i*WIDTH +: WIDTH] = m_q[i];
      eu[i]                = m_upd[i];
      ec[i*CNT_W +: CNT_W] = m_cnt[i];
    end
    chk($sformatf("mix_q_c%0d", cyc), 64'(Q), 64'(eq));
    chk($sformatf("mix_upd_c%0d", cyc), 64'(Updated), 64'(eu));
    chk($sformatf("mix_cnt_c%0d", cyc), 64'(Cap_Cnt), 64'(ec));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    D     = '0;
    En    = '0;
    Mode  = '0;
    Clr   = '0;
    #12;
    chk("rst_q", 64'(Q), 64'h0);
    chk("rst_upd", 64'(Updated), 64'h0);
    chk("rst_cnt", 64'(Cap_Cnt), 64'h0);
    tick();
    rst_n = 1'b1;

    // ch0 level mode
    D[7:0] = 8'hA5; En[0] = 1'b1;
    tick();
    chk("c0_q_a5", 64'(Q[7:0]), 64'hA5);
    chk("c0_upd", 64'(Updated[0]), 64'h1);
    chk("c0_cnt1", 64'(Cap_Cnt[7:0]), 64'h1);
    tick();
    chk("c0_q_a5_hold", 64'(Q[7:0]), 64'hA5);
    chk("c0_cnt_still1", 64'(Cap_Cnt[7:0]), 64'h1);
    D[7:0] = 8'h3C;
    tick();
    chk("c0_q_3c", 64'(Q[7:0]), 64'h3C);
    En[0] = 1'b0; D[7:0] = 8'hFF;
    tick();
    chk("c0_q_hold_3c", 64'(Q[7:0]), 64'h3C);

    // ch1 edge mode
    Mode[1] = 1'b1; D[15:8] = 8'h11; En[1] = 1'b1;
    tick();
    chk("c1_q_11", 64'(Q[15:8]), 64'h11);
    D[15:8] = 8'h22;
    tick();
    chk("c1_q_hold22", 64'(Q[15:8]), 64'h11);
    D[15:8] = 8'h33;
    tick();
    chk("c1_q_hold33", 64'(Q[15:8]), 64'h11);
    En[1] = 1'b0;
    tick();
    En[1] = 1'b1; D[15:8] = 8'h44;
    tick();
    chk("c1_q_44", 64'(Q[15:8]), 64'h44);
    chk("c1_cnt2", 64'(Cap_Cnt[15:8]), 64'h2);
    En[1] = 1'b0;

    // ch2 counter saturation
    D[23:16] = 8'h01;
    for (int p = 1; p <= 300; p++) begin
      En[2] = 1'b1;
      tick();
      En[2] = 1'b0;
      tick();
      if (p == 254) chk("c2_cnt_254", 64'(Cap_Cnt[23:16]), 64'hFE);
      if (p == 255) chk("c2_cnt_255", 64'(Cap_Cnt[23:16]), 64'hFF);
    end
    chk("c2_cnt_sat", 64'(Cap_Cnt[23:16]), 64'hFF);
    chk("c2_q_01", 64'(Q[23:16]), 64'h01);
    Clr[2] = 1'b1;
    tick();
    chk("c2_clr_cnt", 64'(Cap_Cnt[23:16]), 64'h0);
    chk("c2_clr_upd", 64'(Updated[2]), 64'h0);
    En[2] = 1'b1; D[23:16] = 8'h02;
    tick();
    chk("c2_clr_rise_cnt", 64'(Cap_Cnt[23:16]), 64'h1);
    chk("c2_clr_rise_upd", 64'(Updated[2]), 64'h1);
    chk("c2_q_02", 64'(Q[23:16]), 64'h02);
    Clr[2] = 1'b0; En[2] = 1'b0;

    // ch3 identical write and mode change mid-window
    D[31:24] = 8'h55; En[3] = 1'b1;
    tick();
    chk("c3_q_55", 64'(Q[31:24]), 64'h55);
    En[3] = 1'b0; Clr[3] = 1'b1;
    tick();
    chk("c3_clr_upd", 64'(Updated[3]), 64'h0);
    Clr[3] = 1'b0; En[3] = 1'b1;
    tick();
    chk("c3_same_upd", 64'(Updated[3]), 64'h0);
    Mode[3] = 1'b1; D[31:24] = 8'h66;
    tick();
    chk("c3_freeze_q", 64'(Q[31:24]), 64'h55);
    chk("c3_freeze_upd", 64'(Updated[3]), 64'h0);
    En[3] = 1'b0;
    tick();
    En[3] = 1'b1;
    tick();
    chk("c3_rise_q66", 64'(Q[31:24]), 64'h66);
    chk("c3_rise_upd", 64'(Updated[3]), 64'h1);
    chk("c3_cnt2", 64'(Cap_Cnt[31:24]), 64'h2);
    chk("c0_undisturbed", 64'(Q[7:0]), 64'h3C);

    // Async reset while ch0 transparent
    En = 4'b0001; Mode = '0; D[7:0] = 8'h12;
    tick();
    chk("ar_pre_q", 64'(Q[7:0]), 64'h12);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_q", 64'(Q), 64'h0);
    chk("ar_upd", 64'(Updated), 64'h0);
    chk("ar_cnt", 64'(Cap_Cnt), 64'h0);
    D[7:0] = 8'h77;
    tick();
    chk("ar_held_q", 64'(Q), 64'h0);
    #2;
    rst_n = 1'b1;
    #1;
    chk("ar_rel_q", 64'(Q), 64'h0);
    @(posedge clk);
    #1;
    chk("ar_first_q", 64'(Q[7:0]), 64'h77);
    chk("ar_first_cnt", 64'(Cap_Cnt[7:0]), 64'h1);
    chk("ar_first_upd", 64'(Updated[0]), 64'h1);

    // Concurrent activity on all channels against the reference model
    En = '0; Clr = '0; Mode = 4'b1010;
    #2;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      m_q[i] = '0; m_upd[i] = 1'b0; m_cnt[i] = '0; m_en[i] = 1'b0;
    end
    for (int c = 0; c < 48; c++) begin
      for (int i = 0; i < CHANNELS; i++) begin
        D[i*WIDTH +: WIDTH] = 8'((c * (i + 3) * 29 + i * 71) & 8'hFF);
        En[i]   = ((c >> i) & 1) == 1;
        Clr[i]  = ((c + i) % 11) == 0;
      end
      if (c == 24) Mode = 4'b0101;
      model_step();
      tick();
      model_check(c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sync_dlatch_bank.md
Name: sync_dlatch_bank

Overview:
- Parametrised, multi-channel, synchronous replacement for the single level-sensitive D latch.
- Each channel holds a WIDTH-bit value. Per channel, the value is either transparent while its enable is high (level mode) or captured once on the enable's rising edge (edge mode).
- Adds per-channel change flags and saturating capture counters.
- Sits between slow control/config sources and downstream logic that needs held, glitch-free values in the clk domain.

Parameters:
- WIDTH, 8, data bits per channel (>=1).
- CHANNELS, 4, number of independent channels (>=1).
- CNT_W, 8, width of each per-channel capture counter (>=1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- D  input  CHANNELS*WIDTH  channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- En  input  CHANNELS  per-channel enable, sampled on clk.
- Mode  input  CHANNELS  per-channel mode: 0 = level (transparent), 1 = edge capture.
- Clr  input  CHANNELS  per-channel clear of Updated and Cap_Cnt (synchronous, 1-cycle pulse or held).
- Q  output  CHANNELS*WIDTH  held channel data, same packing as D.
- Updated  output  CHANNELS  sticky flag: channel Q changed value since last Clr/reset.
- Cap_Cnt  output  CHANNELS*CNT_W  per-channel count of En rising edges, saturating; channel i at [i*CNT_W +: CNT_W].

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset (rst_n=0, async, any time including mid-window): Q=0, Updated=0, Cap_Cnt=0, internal En_d=0 for all channels. Outputs stay at these values until the first clk rising edge with rst_n=1.
- Channel independence: channels are fully independent; no cross-channel interaction.
- Edge detect:
  - En_d[i] <= En[i] every cycle.
  - rise[i] = En[i] & ~En_d[i], combinational from registered En_d.
  - First cycle after reset release with En=1 counts as a rise.
- Level mode (Mode[i]=0):
  - Any cycle with En[i]=1: Q_i <= D_i at that edge (1-cycle latency, D to Q).
  - En[i]=0: Q_i holds.
- Edge mode (Mode[i]=1):
  - Q_i <= D_i only in a cycle with rise[i]=1.
  - Held for the rest of the En high window and while En is low.
- Mode change: Mode is sampled each cycle, with no state of its own.
  - Level to edge while En high: Q_i freezes at its last loaded value until the next rise.
  - Edge to level while En high: Q_i loads D_i from that cycle on.
- Write event: any cycle in which Q_i is loaded per the rules above.
- Updated[i]:
  - Set when a write event loads a value different from the current Q_i.
  - Writing an identical value does not set it.
  - Clr[i] clears it.
  - Same-cycle set and Clr: set wins (Updated=1).
- Cap_Cnt_i:
  - Increments on rise[i] in either mode.
  - Saturates at 2^CNT_W-1; no wrap-around.
  - Clr[i] with no rise: Cap_Cnt_i <= 0.
  - Clr[i] with rise in the same cycle: Cap_Cnt_i <= 1.
- Clr never affects Q or En_d.
- Arithmetic: counters unsigned; saturation compare against all-ones of CNT_W.

Test Plan:
- Reset, then rst_n=1, ch0 Mode=0, D0=8'hA5, En0=1 for 3 cycles -> Q0=8'hA5 one cycle after En0 sampled high, Updated[0]=1, Cap_Cnt0=1. Change D0=8'h3C with En0 still high -> Q0=8'h3C next cycle. En0=0, D0=8'hFF -> Q0 stays 8'h3C.
- ch1 Mode=1, En1 0->1 with D1=8'h11, hold En1 high while D1 changes to 8'h22, 8'h33 -> Q1=8'h11 throughout. En1 low then high with D1=8'h44 -> Q1=8'h44, Cap_Cnt1=2.
- ch2 (CNT_W=8): pulse En2 high/low 300 times -> Cap_Cnt2 reaches 8'hFF and stays 8'hFF. Clr2 pulse coincident with a rise -> Cap_Cnt2=1, Updated[2]=1 if value changed.
- ch3 Mode=0, Q3=8'h55, En3=1 with D3=8'h55 after Clr3 -> Updated[3] stays 0. Switch Mode3 to 1 mid-window with D3=8'h66 -> Q3 stays 8'h55 until next En3 rise.
- Async reset: assert rst_n=0 between clk edges while ch0 is transparent -> Q, Updated, Cap_Cnt all 0 immediately, without waiting for clk. Release with En0 held 1, D0=8'h77 -> first edge loads Q0=8'h77, Cap_Cnt0=1.
- Simultaneous activity: all 4 channels toggled with distinct patterns -> each channel matches a per-channel reference model, with no cross-channel interference.
